// File: rtl/legv8_pkg.sv
// legv8_pkg
//   Shared definitions for the LEGv8 instruction encoder. This package holds
//   the symbolic operation type, the 11-bit opcodes (the same values the main
//   decoder matches on), the CBZ 8-bit opcode, the field bit positions, the
//   encoder FSM state type and a D-type immediate range helper.
package legv8_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_ORR  = 3'd3,
    OP_LDUR = 3'd4,
    OP_STUR = 3'd5,
    OP_CBZ  = 3'd6
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

  // 11-bit major opcodes, bits [31:21]
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  // CB-type opcode, bits [31:24]
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  // Field bit positions (LSB of each field)
  localparam int unsigned POS_OPC11 = 21;
  localparam int unsigned POS_OPC8  = 24;
  localparam int unsigned POS_RM    = 16;
  localparam int unsigned POS_SHAMT = 10;
  localparam int unsigned POS_DADDR = 12;
  localparam int unsigned POS_OP2   = 10;
  localparam int unsigned POS_CBADR = 5;
  localparam int unsigned POS_RN    = 5;
  localparam int unsigned POS_RD    = 0;

  // D-type offset must fit in signed 9 bits: bits [18:8] all equal bit 8
  function automatic logic d_imm_ok(input logic [18:0] imm);
    return (imm[18:8] == {11{imm[8]}});
  endfunction

endpackage

// File: rtl/legv8_field_pack.sv
// legv8_field_pack
//   Purely combinational field packer: turns a symbolic LEGv8 request into a
//   32-bit machine word and flags requests that cannot be encoded.
// Ports:
//   i_op      : operation code (enc_op_t encoding, 7 is undefined)
//   i_rd      : Rd, or Rt for LDUR/STUR/CBZ
//   i_rn      : Rn
//   i_rm      : Rm (R-type only)
//   i_imm     : signed immediate (D-type offset or CBZ branch offset)
//   o_word    : encoded instruction
//   o_invalid : undefined op or D-type offset outside -256..255
module legv8_field_pack
  import legv8_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rn,
  input  logic [4:0]  i_rm,
  input  logic [18:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_invalid
);

  // Select the encoding format and validity by operation
  always_comb begin
    o_word    = 32'd0;
    o_invalid = 1'b0;
    case (enc_op_t'(i_op))
      OP_ADD:  o_word = {OPC_ADD, i_rm, 6'd0, i_rn, i_rd};
      OP_SUB:  o_word = {OPC_SUB, i_rm, 6'd0, i_rn, i_rd};
      OP_AND:  o_word = {OPC_AND, i_rm, 6'd0, i_rn, i_rd};
      OP_ORR:  o_word = {OPC_ORR, i_rm, 6'd0, i_rn, i_rd};
      OP_LDUR: begin
        o_word    = {OPC_LDUR, i_imm[8:0], 2'b00, i_rn, i_rd};
        o_invalid = !d_imm_ok(i_imm);
      end
      OP_STUR: begin
        o_word    = {OPC_STUR, i_imm[8:0], 2'b00, i_rn, i_rd};
        o_invalid = !d_imm_ok(i_imm);
      end
      OP_CBZ:  o_word = {OPC_CBZ, i_imm, i_rd};
      default: begin
        o_word    = 32'd0;
        o_invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// legv8_instr_encoder
//   Accepts symbolic instruction requests, encodes them and writes the words
//   sequentially into instruction memory through a one-entry output register.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   clear                : synchronous restart (pointer to 0, pending word flushed)
//   req_valid/req_ready  : request handshake
//   req_op/rd/rn/rm/imm  : symbolic request fields
//   imem_we/imem_ready   : memory write handshake
//   imem_addr/imem_wdata : word address and encoded instruction
//   err                  : one-cycle pulse after an invalid request is consumed
//   full                 : DEPTH words accepted since reset/clear
//   count                : number of words accepted
module legv8_instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rn,
  input  logic [4:0]        req_rm,
  input  logic [18:0]       req_imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] L_ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] L_DEPTH    = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] L_DEPTH_M1 = L_DEPTH - L_ONE;

  enc_state_t        r_state;
  enc_state_t        w_state_nx;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [ADDR_W:0]   r_count;

  logic [31:0]       w_word;
  logic              w_invalid;
  logic              w_ready;
  logic              w_acc;
  logic              w_acc_ok;
  logic              w_last;

  legv8_field_pack u_pack (
    .i_op      (req_op),
    .i_rd      (req_rd),
    .i_rn      (req_rn),
    .i_rm      (req_rm),
    .i_imm     (req_imm),
    .o_word    (w_word),
    .o_invalid (w_invalid)
  );

  // The output register may be refilled in the same cycle it drains
  assign w_ready  = !clear && (r_state != ST_FULL) && (!r_we || imem_ready);
  assign w_acc    = req_valid && w_ready;
  assign w_acc_ok = w_acc && !w_invalid;
  assign w_last   = (r_count == L_DEPTH_M1);

  assign req_ready  = w_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign err        = r_err;
  assign full       = (r_state == ST_FULL);
  assign count      = r_count;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic; clear wins over everything
  always_comb begin
    w_state_nx = r_state;
    if (clear) begin
      w_state_nx = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOAD: begin
          if (w_acc_ok) begin
            w_state_nx = w_last ? ST_FULL : ST_LOAD;
          end else begin
            w_state_nx = r_state;
          end
        end
        ST_FULL: w_state_nx = ST_FULL;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // Output register, word counter (doubles as write pointer) and error pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_count <= {(ADDR_W+1){1'b0}};
    end else if (clear) begin
      r_we    <= 1'b0;
      r_addr  <= {ADDR_W{1'b0}};
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_count <= {(ADDR_W+1){1'b0}};
    end else begin
      r_err <= w_acc && w_invalid;
      if (w_acc_ok) begin
        r_we    <= 1'b1;
        r_addr  <= r_count[ADDR_W-1:0];
        r_wdata <= w_word;
        r_count <= r_count + L_ONE;
      end else if (imem_ready) begin
        r_we <= 1'b0;
      end else begin
        r_we <= r_we;
      end
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// tb_legv8_instr_encoder
//   Randomized plus directed bench. The driver applies requests and pushes
//   reference-model expectations into queues; a negedge monitor pops and
//   compares whenever the DUT completes a memory write or pulses err.
module tb_legv8_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk;
  logic              reset_n;
  logic              clear;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rd;
  logic [4:0]        req_rn;
  logic [4:0]        req_rm;
  logic [18:0]       req_imm;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err;
  logic              full;
  logic [ADDR_W:0]   count;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int  m_count = 0;
  bit  m_pending = 0;
  logic [37:0] wq[$];
  bit          eq[$];
  logic [37:0] mon_e;

  legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rn     (req_rn),
    .req_rm     (req_rm),
    .req_imm    (req_imm),
    .imem_we    (imem_we),
    .imem_ready (imem_ready),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .err        (err),
    .full       (full),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder written from the instruction formats with arithmetic
  function automatic logic [31:0] ref_word(input int op, input int rd, input int rn,
                                           input int rm, input int imm, output bit bad);
    longint w;
    longint opc;
    bad = 0;
    w = 0;
    case (op)
      0, 1, 2, 3: begin
        opc = (op == 0) ? 'h458 : (op == 1) ? 'h658 : (op == 2) ? 'h450 : 'h550;
        w = opc * 2097152 + rm * 65536 + rn * 32 + rd;
      end
      4, 5: begin
        opc = (op == 4) ? 'h7C2 : 'h7C0;
        if (imm < -256 || imm > 255) bad = 1;
        w = opc * 2097152 + longint'(imm & 511) * 4096 + rn * 32 + rd;
      end
      6: w = longint'('hB4) * 16777216 + longint'(imm & 'h7FFFF) * 32 + rd;
      default: bad = 1;
    endcase
    return w[31:0];
  endfunction

  // One clock of stimulus; entered and left 1 time unit after a rising edge
  task automatic cycle(input bit v, input int op, input int rd, input int rn, input int rm,
                       input int imm, input bit rdy, input bit clr);
    bit exp_rdy;
    bit acc;
    bit bad;
    logic [31:0] w;
    logic [5:0]  a;
    req_valid  = v;
    req_op     = op[2:0];
    req_rd     = rd[4:0];
    req_rn     = rn[4:0];
    req_rm     = rm[4:0];
    req_imm    = imm[18:0];
    imem_ready = rdy;
    clear      = clr;
    #1;
    exp_rdy = !clr && (m_count < DEPTH) && (!m_pending || rdy);
    check("req_ready", {63'd0, req_ready}, {63'd0, exp_rdy});
    acc = v && exp_rdy;
    w = ref_word(op, rd, rn, rm, imm, bad);
    @(posedge clk);
    if (clr) begin
      if (m_pending && !rdy) void'(wq.pop_back());
      m_count = 0;
      m_pending = 0;
    end else if (acc && !bad) begin
      a = m_count[5:0];
      wq.push_back({a, w});
      m_count++;
      m_pending = 1;
    end else begin
      if (acc) eq.push_back(1'b1);
      if (rdy) m_pending = 0;
    end
    #1;
    check("count", {57'd0, count}, 64'(m_count));
    check("full", {63'd0, full}, {63'd0, (m_count == DEPTH)});
  endtask

  // Monitor: compares completed writes and err pulses against the queues
  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_we && imem_ready) begin
        if (wq.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          mon_e = wq.pop_front();
          check("imem_addr", {58'd0, imem_addr}, {58'd0, mon_e[37:32]});
          check("imem_wdata", {32'd0, imem_wdata}, {32'd0, mon_e[31:0]});
        end
      end
      if (err) begin
        if (eq.size() == 0) check("unexpected_err", 64'd1, 64'd0);
        else begin
          void'(eq.pop_front());
          check("err", {63'd0, err}, 64'd1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, imm, r;
    int bnd[4];
    bnd = '{-256, 255, 256, -257};
    reset_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_op = 3'd0;
    req_rd = 5'd0; req_rn = 5'd0; req_rm = 5'd0; req_imm = 19'd0; imem_ready = 1'b0;
    #2;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_imem_we", {63'd0, imem_we}, 64'd0);
    check("rst_imem_addr", {58'd0, imem_addr}, 64'd0);
    check("rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_count", {57'd0, count}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // directed encodings
    cycle(1, 0, 1, 2, 3, 0, 1, 0);
    check("add_we", {63'd0, imem_we}, 64'd1);
    check("add_addr", {58'd0, imem_addr}, 64'd0);
    check("add_word", {32'd0, imem_wdata}, 64'h8B030041);
    cycle(1, 1, 1, 2, 3, 0, 1, 0);
    check("sub_addr", {58'd0, imem_addr}, 64'd1);
    check("sub_word", {32'd0, imem_wdata}, 64'hCB030041);
    cycle(1, 4, 5, 6, 0, 8, 1, 0);
    check("ldur_word", {32'd0, imem_wdata}, 64'hF84080C5);
    cycle(1, 5, 5, 6, 0, -8, 1, 0);
    check("stur_word", {32'd0, imem_wdata}, 64'hF81F80C5);
    cycle(1, 6, 7, 0, 0, -2, 1, 0);
    check("cbz_word", {32'd0, imem_wdata}, 64'hB4FFFFC7);

    // out-of-range D-type offset
    cycle(1, 4, 5, 6, 0, 256, 1, 0);
    check("err_pulse", {63'd0, err}, 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("err_once", {63'd0, err}, 64'd0);
    cycle(1, 0, 9, 10, 11, 0, 1, 0);
    check("addr_after_err", {58'd0, imem_addr}, 64'd5);

    // backpressure: hold the pending word for three cycles
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3, 4, 4, 4, 0, 0, 0);
      check("bp_we", {63'd0, imem_we}, 64'd1);
      check("bp_addr", {58'd0, imem_addr}, 64'd5);
      check("bp_data", {32'd0, imem_wdata}, 64'h8B0B0149);
    end
    cycle(1, 3, 4, 4, 4, 0, 1, 0);
    check("bp_release_addr", {58'd0, imem_addr}, 64'd6);

    // clear with a simultaneous request, then fill to DEPTH
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 0, 1, 1, 1, 0, 1, 1);
    check("clear_err", {63'd0, err}, 64'd0);
    check("clear_we", {63'd0, imem_we}, 64'd0);
    for (int i = 0; i < DEPTH; i++)
      cycle(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 0, 1, 0);
    cycle(1, 0, 1, 2, 3, 0, 1, 0);
    check("full_flag", {63'd0, full}, 64'd1);
    cycle(1, 0, 1, 2, 3, 0, 1, 1);
    cycle(1, 2, 3, 4, 5, 0, 1, 0);
    check("after_clear_addr", {58'd0, imem_addr}, 64'd0);

    // asynchronous reset with a pending word
    cycle(1, 0, 1, 2, 3, 0, 0, 0);
    check("pend_we", {63'd0, imem_we}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_we", {63'd0, imem_we}, 64'd0);
    check("async_rst_count", {57'd0, count}, 64'd0);
    wq.delete();
    eq.delete();
    m_count = 0;
    m_pending = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 3));
      case (r)
        0: imm = int'($urandom_range(0, 511)) - 256;
        1: imm = bnd[$urandom_range(0, 3)];
        2: imm = int'($urandom_range(0, 524287)) - 262144;
        default: imm = int'($urandom_range(0, 15)) - 8;
      endcase
      cycle($urandom_range(0, 9) < 7, op, int'($urandom_range(0, 31)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), imm,
            $urandom_range(0, 9) < 7,
            (m_count == DEPTH) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) < 2));
    end

    // drain
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check("writes_outstanding", 64'(wq.size()), 64'd0);
    check("errs_outstanding", 64'(eq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/legv8_instr_encoder.md
# legv8_instr_encoder

Instruction encoder and loader for the single-cycle LEGv8 core. It is the inverse of the main opcode decoder. It accepts symbolic instruction requests (operation plus register and immediate fields), assembles each one into a 32-bit LEGv8 machine word, and writes the words sequentially into instruction memory through a ready/valid write port with a one-entry output register. The bench and boot logic use it to load programs without hand-assembled hex.

## Interface
- `ADDR_W`, default 6: instruction-memory word-address width.
- `DEPTH`, default 64: number of writable words, with `DEPTH <= 2**ADDR_W`.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous restart; pointer goes to 0 and any pending word is flushed.
- `req_valid` in 1: request present.
- `req_ready` out 1: encoder can accept a request.
- `req_op` in 3: `enc_op_t`, one of ADD, SUB, AND, ORR, LDUR, STUR, CBZ.
- `req_rd` in 5: Rd, or Rt for LDUR/STUR/CBZ.
- `req_rn` in 5: Rn.
- `req_rm` in 5: Rm (R-type only).
- `req_imm` in 19: signed immediate; DT_address for D-type, COND_BR_address for CBZ.
- `imem_we` out 1: write valid.
- `imem_ready` in 1: memory accepts the write.
- `imem_addr` out ADDR_W: word address.
- `imem_wdata` out 32: encoded instruction.
- `err` out 1: one-cycle pulse when a request is rejected.
- `full` out 1: DEPTH words have been accepted since the last reset or clear.
- `count` out ADDR_W+1: number of words accepted.

## Operation
- **Encoding:**
  - R-type: opcode[31:21], Rm[20:16], shamt[15:10]=0, Rn[9:5], Rd[4:0]. Opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
  - D-type: opcode[31:21], imm[8:0] in bits [20:12], op2[11:10]=00, Rn[9:5], Rt[4:0]. Opcodes: LDUR 11111000010, STUR 11111000000.
  - CB-type: [31:24]=10110100, imm[18:0] in bits [23:5], Rt[4:0].
- **Range check:** for D-type, `req_imm` must lie in -256..255, i.e. bits [18:8] are all equal to bit 8. Undefined `req_op` codes (7) are also invalid.
- **Invalid requests:** an invalid request is still handshaken (consumed). Nothing is written, the pointer does not advance, and `err` pulses in the following cycle.
- **Valid requests:** the word is loaded into the output register with `imem_addr = ptr`, `ptr` increments, and `count` increments.
- **FSM states:** IDLE, LOAD, FULL.
  - IDLE → LOAD on the first accepted valid request.
  - LOAD → FULL when `count` reaches DEPTH.
  - Any state → IDLE on `clear`.
- **req_ready:** `req_ready = !clear && state != FULL && (!imem_we || imem_ready)`.
- **In FULL:** `req_ready` = 0 and no request is consumed. The last word still drains.
- **Output handshake:** `imem_we`, `imem_addr` and `imem_wdata` hold stable until `imem_ready`.
- **clear vs. request:** `clear` has priority over a simultaneous request; that request is not accepted.
- **clear flushes:** `clear` also flushes a pending word. `imem_we` = 0 in the next cycle.

## Timing
- **Reset values:** `req_ready` = 1, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0, `err` = 0, `full` = 0, `count` = 0, state IDLE.
- **Latency:** a request accepted at edge N presents `imem_we` = 1 after edge N, with a registered output.
- **Throughput:** one word per cycle while `imem_ready` = 1.
- **Backpressure:** `imem_ready` = 0 while `imem_we` = 1 drops `req_ready` combinationally. There is no skid beyond the one-entry register.
- **full flag:** `full` rises in the cycle after the DEPTH-th accept. `count` saturates at DEPTH.
- **Reset mid-transfer:** asserting `reset_n` low mid-transfer drops `imem_we` immediately (asynchronous); the pending word is lost.

## Structure
- Package `legv8_pkg` holds `enc_op_t`, the 11-bit opcode constants (shared with the decoder), the CBZ 8-bit opcode, and the field bit-position localparams.
- Sub-module `legv8_field_pack` is purely combinational: op/fields in → word plus `invalid`. The top level holds the FSM, pointer and output register.

## Test plan
- ADD X1,X2,X3 with `imem_ready` = 1 → `imem_wdata` = 0x8B030041 at addr 0 one cycle after accept. SUB with the same fields → 0xCB030041 at addr 1.
- LDUR X5,[X6,#8] → 0xF84080C5. STUR X5,[X6,#-8] → 0xF81F80C5. CBZ X7,#-2 → 0xB4FFFFC7.
- LDUR with imm = 256 → `err` pulses once, no write, next valid request lands at the unchanged address.
- Hold `imem_ready` = 0 for 3 cycles with a word pending → data and address stable, `req_ready` = 0. Then release → one write, next request accepted the same cycle.
- Stream DEPTH = 64 valid requests → addresses 0..63, `full` = 1, `req_ready` = 0 afterward. Then `clear` → `count` = 0, next write at addr 0.
- Assert `reset_n` low with a word pending → `imem_we` = 0 without waiting for a clock. Assert `clear` together with `req_valid` → request not accepted, `err` = 0.
